// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the LSU dmem arbiter.
// Holds the FSM state encoding, the latched request layout and the
// default starvation limit.
package dmem_arbiter_pkg;

    localparam int STARVE_LIMIT_DEF = 4;

    typedef logic [1:0] dmem_arb_state_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY_LD = 2'd1;
    localparam logic [1:0] BUSY_ST = 2'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  mask;
        logic [31:0] wdata;
        logic        is_store;
    } dmem_req_t;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single dmem port between the load path and the
// committed-store drain path. One outstanding transaction; the winning
// request is latched and held on dmem until dmem_resp.
// Optional macro DMEM_ARBITER_PERF_EN adds 32-bit wrapping perf counters.
//
//  state   | meaning
//  --------+------------------------------------------------------------
//  IDLE    | no transaction; at most one request accepted this cycle
//  BUSY_LD | latched load on dmem, waiting for dmem_resp
//  BUSY_ST | latched store on dmem, waiting for dmem_resp
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ld_req_valid,
    output logic        ld_req_ready,
    input  logic [31:0] ld_req_addr,
    input  logic [3:0]  ld_req_mask,
    output logic        ld_resp_valid,
    output logic [31:0] ld_resp_rdata,
    input  logic        st_req_valid,
    output logic        st_req_ready,
    input  logic [31:0] st_req_addr,
    input  logic [3:0]  st_req_mask,
    input  logic [31:0] st_req_wdata,
    output logic        st_resp_valid,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_rmask,
    output logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
`ifdef DMEM_ARBITER_PERF_EN
    ,
    output logic [31:0] perf_ld_grants,
    output logic [31:0] perf_st_grants,
    output logic [31:0] perf_starve_forced,
    output logic [31:0] perf_busy_cycles
`endif
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    dmem_arb_state_t       state;
    dmem_arb_state_t       state_nxt;
    logic [STARVE_W-1:0]   starve_cnt;
    logic                  kill;
    dmem_req_t             req_q;

    logic                  idle;
    logic                  ld_cand;
    logic                  starved;
    logic                  ld_grant;
    logic                  st_grant;
    logic                  busy_ld;
    logic                  busy_st;

    // dmem is word addressed; the byte offset is carried by the mask
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{ld_req_addr[1:0], st_req_addr[1:0]};

    // Outputs are gated by rst so nothing is asserted during the reset cycle,
    // even when the registers still hold a BUSY state.
    assign idle    = rst && (state == IDLE);
    assign busy_ld = rst && (state == BUSY_LD) && !req_q.is_store;
    assign busy_st = rst && (state == BUSY_ST) && req_q.is_store;

    // A flushed load cannot be granted, so it must not hold the store off either.
    assign ld_cand  = ld_req_valid && !flush;
    assign starved  = (starve_cnt == STARVE_MAX);
    assign st_grant = idle && st_req_valid && !(ld_cand && starved);
    assign ld_grant = idle && ld_cand && (!st_req_valid || starved);

    assign ld_req_ready  = ld_grant;
    assign st_req_ready  = st_grant;

    assign dmem_addr     = req_q.addr;
    assign dmem_wdata    = req_q.wdata;
    assign dmem_rmask    = (busy_ld && !dmem_resp) ? req_q.mask : 4'b0000;
    assign dmem_wmask    = (busy_st && !dmem_resp) ? req_q.mask : 4'b0000;

    assign ld_resp_rdata = dmem_rdata;
    assign ld_resp_valid = busy_ld && dmem_resp && !kill && !flush;
    assign st_resp_valid = busy_st && dmem_resp;

    // Next-state selection
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ld_grant)      state_nxt = BUSY_LD;
                else if (st_grant) state_nxt = BUSY_ST;
            end
            BUSY_LD, BUSY_ST: begin
                if (dmem_resp) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, request latch, load-kill flag and starvation counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            kill       <= 1'b0;
            req_q      <= '0;
        end else begin
            state <= state_nxt;

            if (ld_grant) begin
                req_q.addr     <= {ld_req_addr[31:2], 2'b00};
                req_q.mask     <= ld_req_mask;
                req_q.wdata    <= '0;
                req_q.is_store <= 1'b0;
            end else if (st_grant) begin
                req_q.addr     <= {st_req_addr[31:2], 2'b00};
                req_q.mask     <= st_req_mask;
                req_q.wdata    <= st_req_wdata;
                req_q.is_store <= 1'b1;
            end

            if (state_nxt == IDLE)
                kill <= 1'b0;
            else if ((state == BUSY_LD) && flush)
                kill <= 1'b1;

            if (ld_grant || !ld_req_valid)
                starve_cnt <= '0;
            else if (st_grant && !starved)
                starve_cnt <= starve_cnt + STARVE_W'(1);
        end
    end

`ifdef DMEM_ARBITER_PERF_EN
    // Wrapping event counters for grants, forced loads and busy cycles
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_ld_grants     <= '0;
            perf_st_grants     <= '0;
            perf_starve_forced <= '0;
            perf_busy_cycles   <= '0;
        end else begin
            if (ld_grant)                 perf_ld_grants     <= perf_ld_grants + 32'd1;
            if (st_grant)                 perf_st_grants     <= perf_st_grants + 32'd1;
            if (ld_grant && st_req_valid) perf_starve_forced <= perf_starve_forced + 32'd1;
            if (state != IDLE)            perf_busy_cycles   <= perf_busy_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, lone load, store/load starvation
// pattern, flush in each state and reset in the middle of a store.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ld_req_valid;
    logic        ld_req_ready;
    logic [31:0] ld_req_addr;
    logic [3:0]  ld_req_mask;
    logic        ld_resp_valid;
    logic [31:0] ld_resp_rdata;
    logic        st_req_valid;
    logic        st_req_ready;
    logic [31:0] st_req_addr;
    logic [3:0]  st_req_mask;
    logic [31:0] st_req_wdata;
    logic        st_resp_valid;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
`ifdef DMEM_ARBITER_PERF_EN
    logic [31:0] perf_ld_grants;
    logic [31:0] perf_st_grants;
    logic [31:0] perf_starve_forced;
    logic [31:0] perf_busy_cycles;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .ld_req_valid  (ld_req_valid),
        .ld_req_ready  (ld_req_ready),
        .ld_req_addr   (ld_req_addr),
        .ld_req_mask   (ld_req_mask),
        .ld_resp_valid (ld_resp_valid),
        .ld_resp_rdata (ld_resp_rdata),
        .st_req_valid  (st_req_valid),
        .st_req_ready  (st_req_ready),
        .st_req_addr   (st_req_addr),
        .st_req_mask   (st_req_mask),
        .st_req_wdata  (st_req_wdata),
        .st_resp_valid (st_resp_valid),
        .dmem_addr     (dmem_addr),
        .dmem_rmask    (dmem_rmask),
        .dmem_wmask    (dmem_wmask),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_resp     (dmem_resp)
`ifdef DMEM_ARBITER_PERF_EN
        ,
        .perf_ld_grants     (perf_ld_grants),
        .perf_st_grants     (perf_st_grants),
        .perf_starve_forced (perf_starve_forced),
        .perf_busy_cycles   (perf_busy_cycles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Move to just after the next rising edge; inputs are driven here and
    // outputs sampled one time unit later.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_ld;
        rst = 1'b0; flush = 1'b0;
        ld_req_valid = 1'b0; ld_req_addr = '0; ld_req_mask = '0;
        st_req_valid = 1'b0; st_req_addr = '0; st_req_mask = '0; st_req_wdata = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;

        // Reset cycle: requests present, nothing may be accepted or asserted
        cyc();
        ld_req_valid = 1'b1; ld_req_mask = 4'hF;
        st_req_valid = 1'b1; st_req_mask = 4'hF;
        dmem_resp = 1'b1;
        #1;
        chk("rst_ld_ready", ld_req_ready, 0);
        chk("rst_st_ready", st_req_ready, 0);
        chk("rst_rmask", dmem_rmask, 0);
        chk("rst_wmask", dmem_wmask, 0);
        chk("rst_ld_resp", ld_resp_valid, 0);
        chk("rst_st_resp", st_resp_valid, 0);
        cyc();
        rst = 1'b1; ld_req_valid = 1'b0; st_req_valid = 1'b0; dmem_resp = 1'b0;
        #1;
        chk("post_rst_rmask", dmem_rmask, 0);

        // Both requesters valid continuously: ST,ST,ST,ST,LD repeating
        for (int i = 0; i < 10; i++) begin
            exp_ld = (i % 5 == 4);
            cyc();
            ld_req_valid = 1'b1; ld_req_addr = 32'h100 + i * 16 + 2; ld_req_mask = 4'b1100;
            st_req_valid = 1'b1; st_req_addr = 32'h800 + i * 16 + 3; st_req_mask = 4'b0011;
            st_req_wdata = 32'hC0DE_0000 + i;
            dmem_resp = 1'b0;
            #1;
            chk($sformatf("arb%0d_ld_ready", i), ld_req_ready, exp_ld);
            chk($sformatf("arb%0d_st_ready", i), st_req_ready, !exp_ld);
            cyc();
            #1;
            chk($sformatf("arb%0d_busy_ld_ready", i), ld_req_ready, 0);
            chk($sformatf("arb%0d_rmask", i), dmem_rmask, exp_ld ? 4'b1100 : 4'b0000);
            chk($sformatf("arb%0d_wmask", i), dmem_wmask, exp_ld ? 4'b0000 : 4'b0011);
            chk($sformatf("arb%0d_addr", i), dmem_addr, exp_ld ? 32'h100 + i * 16 : 32'h800 + i * 16);
            if (!exp_ld) chk($sformatf("arb%0d_wdata", i), dmem_wdata, 32'hC0DE_0000 + i);
            cyc();
            dmem_resp = 1'b1; dmem_rdata = 32'h1234_0000 + i;
            #1;
            chk($sformatf("arb%0d_ld_resp", i), ld_resp_valid, exp_ld);
            chk($sformatf("arb%0d_st_resp", i), st_resp_valid, !exp_ld);
        end
        cyc();
        dmem_resp = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0;
        #1;
`ifdef DMEM_ARBITER_PERF_EN
        chk("perf_ld", perf_ld_grants, 2);
        chk("perf_st", perf_st_grants, 8);
        chk("perf_forced", perf_starve_forced, 2);
        chk("perf_busy", perf_busy_cycles, 20);
`endif

        // Lone load, cache answers three cycles after accept
        cyc();
        ld_req_valid = 1'b1; ld_req_addr = 32'h1003; ld_req_mask = 4'b1000;
        #1;
        chk("lone_ld_ready", ld_req_ready, 1);
        chk("lone_st_ready", st_req_ready, 0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            ld_req_valid = 1'b0; ld_req_addr = 32'hFFFF_FFFF; ld_req_mask = 4'b0001;
            #1;
            chk($sformatf("lone_addr%0d", k), dmem_addr, 32'h1000);
            chk($sformatf("lone_rmask%0d", k), dmem_rmask, 4'b1000);
            chk($sformatf("lone_wmask%0d", k), dmem_wmask, 0);
            chk($sformatf("lone_noresp%0d", k), ld_resp_valid, 0);
        end
        cyc();
        dmem_resp = 1'b1; dmem_rdata = 32'hAABBCCDD;
        #1;
        chk("lone_resp", ld_resp_valid, 1);
        chk("lone_rdata", ld_resp_rdata, 32'hAABBCCDD);
        chk("lone_resp_rmask", dmem_rmask, 0);
        cyc();
        dmem_resp = 1'b0;
        #1;
        chk("lone_resp_done", ld_resp_valid, 0);

        // Flush in IDLE blocks the load; with a store also valid the store wins
        cyc();
        flush = 1'b1; ld_req_valid = 1'b1; ld_req_addr = 32'h5000; ld_req_mask = 4'b0001;
        #1;
        chk("flush_idle_ld_ready", ld_req_ready, 0);
        cyc();
        st_req_valid = 1'b1; st_req_addr = 32'h7000; st_req_mask = 4'b1111;
        #1;
        chk("flush_idle_st_ready", st_req_ready, 1);
        chk("flush_idle_ld_ready2", ld_req_ready, 0);
        cyc();
        flush = 1'b0; ld_req_valid = 1'b0; st_req_valid = 1'b0; dmem_resp = 1'b1;
        #1;
        chk("flush_idle_st_resp", st_resp_valid, 1);

        // Flush during BUSY_LD: request held, response suppressed
        cyc();
        dmem_resp = 1'b0; ld_req_valid = 1'b1;
        #1;
        chk("kill_accept", ld_req_ready, 1);
        cyc();
        ld_req_valid = 1'b0; flush = 1'b1;
        #1;
        chk("kill_rmask_flush", dmem_rmask, 4'b0001);
        cyc();
        flush = 1'b0;
        #1;
        chk("kill_rmask_held", dmem_rmask, 4'b0001);
        cyc();
        dmem_resp = 1'b1;
        #1;
        chk("kill_resp_suppressed", ld_resp_valid, 0);
        cyc();
        dmem_resp = 1'b0; ld_req_valid = 1'b1; ld_req_addr = 32'h5004; ld_req_mask = 4'b0010;
        #1;
        chk("kill_next_accept", ld_req_ready, 1);
        cyc();
        ld_req_valid = 1'b0;
        #1;
        chk("kill_next_rmask", dmem_rmask, 4'b0010);
        cyc();
        dmem_resp = 1'b1; dmem_rdata = 32'h0BAD_F00D;
        #1;
        chk("kill_cleared_resp", ld_resp_valid, 1);
        chk("kill_cleared_rdata", ld_resp_rdata, 32'h0BAD_F00D);

        // Flush landing in the response cycle of a load
        cyc();
        dmem_resp = 1'b0; ld_req_valid = 1'b1;
        #1;
        chk("late_flush_accept", ld_req_ready, 1);
        cyc();
        ld_req_valid = 1'b0; dmem_resp = 1'b1; flush = 1'b1;
        #1;
        chk("late_flush_resp", ld_resp_valid, 0);

        // Flush during BUSY_ST has no effect
        cyc();
        dmem_resp = 1'b0; flush = 1'b0;
        st_req_valid = 1'b1; st_req_addr = 32'h6000; st_req_mask = 4'b1001;
        #1;
        chk("st_flush_accept", st_req_ready, 1);
        cyc();
        st_req_valid = 1'b0; flush = 1'b1;
        #1;
        chk("st_flush_wmask", dmem_wmask, 4'b1001);
        cyc();
        dmem_resp = 1'b1;
        #1;
        chk("st_flush_resp", st_resp_valid, 1);

        // Reset in the middle of a store
        cyc();
        dmem_resp = 1'b0; flush = 1'b0;
        st_req_valid = 1'b1; st_req_addr = 32'h3004; st_req_mask = 4'b0110;
        #1;
        chk("mid_rst_accept", st_req_ready, 1);
        cyc();
        st_req_valid = 1'b0;
        #1;
        chk("mid_rst_wmask_before", dmem_wmask, 4'b0110);
        cyc();
        rst = 1'b0; st_req_valid = 1'b1;
        #1;
        chk("mid_rst_wmask", dmem_wmask, 0);
        chk("mid_rst_st_ready", st_req_ready, 0);
        cyc();
        rst = 1'b1; st_req_addr = 32'h4008; st_req_mask = 4'b1111; st_req_wdata = 32'h5555_AAAA;
        #1;
        chk("after_rst_wmask", dmem_wmask, 0);
        chk("after_rst_st_ready", st_req_ready, 1);
        cyc();
        st_req_valid = 1'b0;
        #1;
        chk("after_rst_busy_wmask", dmem_wmask, 4'b1111);
        chk("after_rst_addr", dmem_addr, 32'h4008);
        chk("after_rst_wdata", dmem_wdata, 32'h5555_AAAA);
        cyc();
        dmem_resp = 1'b1;
        #1;
        chk("after_rst_st_resp", st_resp_valid, 1);
        cyc();
        dmem_resp = 1'b0;
        #1;
        chk("after_rst_idle", st_resp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
